// File: rtl/noc_pkg.sv
// Shared constants and types for the 7-port wormhole router.
// Port indices, flit-type codes and the per-output allocator state.
package noc_pkg;

    localparam int NPORT = 7;
    localparam int PW    = 3;
    localparam int FW    = 40;

    localparam logic [PW-1:0] P_E    = 3'd0;
    localparam logic [PW-1:0] P_W    = 3'd1;
    localparam logic [PW-1:0] P_N    = 3'd2;
    localparam logic [PW-1:0] P_S    = 3'd3;
    localparam logic [PW-1:0] P_PE   = 3'd4;
    localparam logic [PW-1:0] P_UP   = 3'd5;
    localparam logic [PW-1:0] P_DOWN = 3'd6;

    localparam logic [1:0] FT_HEAD   = 2'b11;
    localparam logic [1:0] FT_BODY   = 2'b10;
    localparam logic [1:0] FT_TAIL   = 2'b01;
    localparam logic [1:0] FT_SINGLE = 2'b00;

    localparam logic [PW-1:0] DST_NONE = 3'd7;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_e;

    // Successor of a port index, wrapping 6 -> 0.
    function automatic logic [PW-1:0] nxt_port(input logic [PW-1:0] p);
        return (p == P_DOWN) ? P_E : p + 3'd1;
    endfunction

endpackage

// File: rtl/rr_arb7.sv
// Combinational 7-way round-robin picker.
// Searches ptr, ptr+1, ... mod 7 and reports the first requester.
module rr_arb7
    import noc_pkg::*;
(
    input  logic [NPORT-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic             vld_o,
    output logic [PW-1:0]    idx_o
);

    int j;

    // Walk from the far end back so the closest-to-pointer hit wins.
    always_comb begin
        vld_o = 1'b0;
        idx_o = '0;
        j     = 0;
        for (int k = NPORT - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k;
            if (j >= NPORT) j = j - NPORT;
            if (req_i[j]) begin
                vld_o = 1'b1;
                idx_o = PW'(j);
            end
        end
    end

endmodule

// File: rtl/wormhole_sw_arbiter.sv
// Switch allocator for the 7-port wormhole router.
// One round-robin arbiter per output; outputs stay locked until the tail.
module wormhole_sw_arbiter
    import noc_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [NPORT-1:0]    req_vld,
    input  logic [NPORT*PW-1:0] req_dst,
    input  logic [NPORT*2-1:0]  flit_type,
    input  logic [NPORT-1:0]    out_ready,
    output logic [NPORT-1:0]    rd_en,
    output logic [NPORT-1:0]    out_vld,
    output logic [NPORT*PW-1:0] out_sel,
    output logic [NPORT-1:0]    out_busy,
    output logic                err
);

    state_e        state_q [NPORT];
    state_e        state_d [NPORT];
    logic [PW-1:0] owner_q [NPORT];
    logic [PW-1:0] owner_d [NPORT];
    logic [PW-1:0] ptr_q   [NPORT];
    logic [PW-1:0] ptr_d   [NPORT];
    logic [NPORT-1:0] started_q, started_d;
    logic [NPORT-1:0] stray_q, stray_d;
    logic err_q, err_d;

    logic [1:0]       ft   [NPORT];
    logic [PW-1:0]    dst  [NPORT];
    logic [NPORT-1:0] cand [NPORT];
    logic [PW-1:0]    gnt_idx [NPORT];
    logic [NPORT-1:0] gnt_vld;
    logic [NPORT-1:0] owned;
    logic [NPORT-1:0] xfer;
    logic [1:0]       ft_own;

    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            ft[i]  = flit_type[2*i +: 2];
            dst[i] = req_dst[PW*i +: PW];
        end
    end

    always_comb begin
        owned = '0;
        xfer  = '0;
        for (int o = 0; o < NPORT; o++) begin
            if (state_q[o] == S_LOCKED) begin
                owned[owner_q[o]] = 1'b1;
                xfer[o] = req_vld[owner_q[o]] & out_ready[o];
            end
        end
    end

    // Only packet starts at inputs not already streaming are eligible.
    always_comb begin
        for (int o = 0; o < NPORT; o++) begin
            for (int i = 0; i < NPORT; i++) begin
                cand[o][i] = req_vld[i]
                           & (ft[i] == FT_HEAD || ft[i] == FT_SINGLE)
                           & (dst[i] == PW'(o))
                           & (i != o)
                           & ~owned[i];
            end
        end
    end

    for (genvar g = 0; g < NPORT; g++) begin : g_arb
        rr_arb7 u_arb (
            .req_i (cand[g]),
            .ptr_i (ptr_q[g]),
            .vld_o (gnt_vld[g]),
            .idx_o (gnt_idx[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < NPORT; o++) begin
                state_q[o] <= S_IDLE;
                owner_q[o] <= '0;
                ptr_q[o]   <= '0;
            end
            started_q <= '0;
            stray_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            for (int o = 0; o < NPORT; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                ptr_q[o]   <= ptr_d[o];
            end
            started_q <= started_d;
            stray_q   <= stray_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        err_d     = err_q;
        started_d = started_q;
        stray_d   = '0;
        ft_own    = FT_SINGLE;
        for (int o = 0; o < NPORT; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            ptr_d[o]   = ptr_q[o];
            ft_own     = ft[owner_q[o]];
            unique case (state_q[o])
                S_IDLE: begin
                    if (gnt_vld[o]) begin
                        state_d[o]   = S_LOCKED;
                        owner_d[o]   = gnt_idx[o];
                        ptr_d[o]     = nxt_port(gnt_idx[o]);
                        started_d[o] = 1'b0;
                    end
                end
                S_LOCKED: begin
                    if (xfer[o]) begin
                        started_d[o] = 1'b1;
                        if (ft_own == FT_HEAD && started_q[o]) err_d = 1'b1;
                        if (ft_own == FT_TAIL || ft_own == FT_SINGLE)
                            state_d[o] = S_IDLE;
                    end
                end
            endcase
        end
        for (int i = 0; i < NPORT; i++) begin
            stray_d[i] = req_vld[i] & ~owned[i]
                       & (ft[i] == FT_BODY || ft[i] == FT_TAIL);
            if (stray_d[i] && stray_q[i]) err_d = 1'b1;
            if (req_vld[i] && ft[i] == FT_HEAD
                && (dst[i] == PW'(i) || dst[i] == DST_NONE))
                err_d = 1'b1;
        end
    end

    always_comb begin
        rd_en    = '0;
        out_vld  = '0;
        out_sel  = '0;
        out_busy = '0;
        if (!rst) begin
            for (int o = 0; o < NPORT; o++) begin
                if (state_q[o] == S_LOCKED) begin
                    rd_en[owner_q[o]]    = rd_en[owner_q[o]] | xfer[o];
                    out_vld[o]           = xfer[o];
                    out_sel[PW*o +: PW]  = owner_q[o];
                    out_busy[o]          = 1'b1;
                end
            end
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_wormhole_sw_arbiter.sv
// Randomised and directed bench for wormhole_sw_arbiter.
// Input FIFOs are queues; a packet-level model predicts every cycle.
module tb_wormhole_sw_arbiter;

    localparam int NP = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  req_vld, out_ready, rd_en, out_vld, out_busy;
    logic [20:0] req_dst, out_sel;
    logic [13:0] flit_type;
    logic        err;

    always #5 clk = ~clk;

    wormhole_sw_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_vld   (req_vld),
        .req_dst   (req_dst),
        .flit_type (flit_type),
        .out_ready (out_ready),
        .rd_en     (rd_en),
        .out_vld   (out_vld),
        .out_sel   (out_sel),
        .out_busy  (out_busy),
        .err       (err)
    );

    typedef logic [4:0] fl_t;
    fl_t fq [NP][$];

    int m_own   [NP];
    int m_ptr   [NP];
    bit m_start [NP];
    bit m_stray [NP];
    bit m_err;

    int rd_cnt [NP];
    int olog   [NP][$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            m_own[i] = -1; m_ptr[i] = 0;
            m_start[i] = 0; m_stray[i] = 0;
        end
        m_err = 0;
    endtask

    task automatic clear_logs();
        for (int i = 0; i < NP; i++) begin
            rd_cnt[i] = 0;
            olog[i].delete();
        end
    endtask

    task automatic push_pkt(input int src, input int d, input int len);
        logic [2:0] dd = 3'(d);
        if (len == 1) fq[src].push_back({2'b00, dd});
        else begin
            fq[src].push_back({2'b11, dd});
            for (int k = 0; k < len - 2; k++) fq[src].push_back({2'b10, dd});
            fq[src].push_back({2'b01, dd});
        end
    endtask

    task automatic step(input bit r, input logic [6:0] rdy, input logic [6:0] gap);
        logic [6:0]  e_rd, e_vld, e_busy;
        logic [20:0] e_sel;
        logic        e_err;
        bit owned [NP];
        int w, i, ft, ds;
        @(negedge clk);
        rst = r;
        out_ready = rdy;
        for (int p = 0; p < NP; p++) begin
            if (fq[p].size() > 0 && !gap[p]) begin
                req_vld[p] = 1'b1;
                flit_type[2*p +: 2] = fq[p][0][4:3];
                req_dst[3*p +: 3]   = fq[p][0][2:0];
            end else begin
                req_vld[p] = 1'b0;
                flit_type[2*p +: 2] = 2'($urandom);
                req_dst[3*p +: 3]   = 3'($urandom);
            end
        end
        #1;
        e_rd = '0; e_vld = '0; e_busy = '0; e_sel = '0; e_err = m_err;
        if (!r) begin
            for (int o = 0; o < NP; o++) begin
                if (m_own[o] >= 0) begin
                    w = m_own[o];
                    e_busy[o] = 1'b1;
                    e_sel[3*o +: 3] = 3'(w);
                    if (req_vld[w] && rdy[o]) begin
                        e_vld[o] = 1'b1;
                        e_rd[w] = 1'b1;
                    end
                end
            end
        end
        n_cmp++;
        if (rd_en !== e_rd) begin
            n_bad++; $display("FAIL rd_en t=%0t got %b exp %b", $time, rd_en, e_rd);
        end
        n_cmp++;
        if (out_vld !== e_vld) begin
            n_bad++; $display("FAIL out_vld t=%0t got %b exp %b", $time, out_vld, e_vld);
        end
        n_cmp++;
        if (out_busy !== e_busy) begin
            n_bad++; $display("FAIL out_busy t=%0t got %b exp %b", $time, out_busy, e_busy);
        end
        n_cmp++;
        if (out_sel !== e_sel) begin
            n_bad++; $display("FAIL out_sel t=%0t got %h exp %h", $time, out_sel, e_sel);
        end
        n_cmp++;
        if (err !== e_err) begin
            n_bad++; $display("FAIL err t=%0t got %b exp %b", $time, err, e_err);
        end
        for (int p = 0; p < NP; p++) begin
            if (rd_en[p] === 1'b1) rd_cnt[p]++;
            if (out_vld[p] === 1'b1) olog[p].push_back(int'(out_sel[3*p +: 3]));
        end
        if (r) model_reset();
        else begin
            for (int p = 0; p < NP; p++) owned[p] = 0;
            for (int o = 0; o < NP; o++) if (m_own[o] >= 0) owned[m_own[o]] = 1;
            for (int p = 0; p < NP; p++) begin
                ft = int'(flit_type[2*p +: 2]);
                ds = int'(req_dst[3*p +: 3]);
                if (req_vld[p] && (ft == 2 || ft == 1) && !owned[p]) begin
                    if (m_stray[p]) m_err = 1;
                    m_stray[p] = 1;
                end else m_stray[p] = 0;
                if (req_vld[p] && ft == 3 && (ds == p || ds == 7)) m_err = 1;
            end
            for (int o = 0; o < NP; o++) begin
                if (m_own[o] >= 0) begin
                    w = m_own[o];
                    ft = int'(flit_type[2*w +: 2]);
                    if (req_vld[w] && rdy[o]) begin
                        if (ft == 3 && m_start[o]) m_err = 1;
                        m_start[o] = 1;
                        if (ft == 1 || ft == 0) m_own[o] = -1;
                    end
                end else begin
                    for (int k = 0; k < NP; k++) begin
                        i = (m_ptr[o] + k) % NP;
                        ft = int'(flit_type[2*i +: 2]);
                        ds = int'(req_dst[3*i +: 3]);
                        if (req_vld[i] && (ft == 3 || ft == 0) && ds == o
                            && i != o && !owned[i]) begin
                            m_own[o] = i;
                            m_ptr[o] = (i + 1) % NP;
                            m_start[o] = 0;
                            break;
                        end
                    end
                end
            end
        end
        for (int p = 0; p < NP; p++)
            if (e_rd[p] && fq[p].size() > 0) void'(fq[p].pop_front());
    endtask

    task automatic do_reset();
        for (int i = 0; i < NP; i++) fq[i].delete();
        step(1'b1, 7'h7f, 7'h00);
        step(1'b1, 7'h7f, 7'h00);
        clear_logs();
    endtask

    task automatic test_reset();
        model_reset();
        do_reset();
        step(1'b0, 7'h7f, 7'h00);
    endtask

    task automatic test_single();
        do_reset();
        push_pkt(1, 0, 4);
        step(1'b0, 7'h7f, 7'h00);
        step(1'b0, 7'h7f, 7'h00);
        n_cmp++;
        if (out_busy[0] !== 1'b1 || rd_en !== 7'b0000010) begin
            n_bad++;
            $display("FAIL single_first got busy=%b rd=%b exp busy=1 rd=0000010", out_busy[0], rd_en);
        end
        for (int c = 0; c < 6; c++) step(1'b0, 7'h7f, 7'h00);
        n_cmp++;
        if (rd_cnt[1] !== 4) begin
            n_bad++; $display("FAIL single_reads got %0d exp 4", rd_cnt[1]);
        end
    endtask

    task automatic test_contention();
        int exp_q [$];
        do_reset();
        push_pkt(2, 5, 2);
        push_pkt(3, 5, 2);
        push_pkt(4, 5, 2);
        for (int c = 0; c < 14; c++) step(1'b0, 7'h7f, 7'h00);
        exp_q = '{2, 2, 3, 3, 4, 4};
        n_cmp++;
        if (olog[5] != exp_q) begin
            n_bad++; $display("FAIL contention_order got %p exp %p", olog[5], exp_q);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        push_pkt(1, 0, 5);
        for (int c = 0; c < 14; c++) begin
            if (c >= 3 && c <= 5) step(1'b0, 7'h7e, 7'h00);
            else step(1'b0, 7'h7f, 7'h00);
        end
        n_cmp++;
        if (rd_cnt[1] !== 5 || olog[0].size() != 5) begin
            n_bad++; $display("FAIL backpressure_reads got %0d exp 5", rd_cnt[1]);
        end
    endtask

    task automatic test_parallel();
        do_reset();
        push_pkt(0, 1, 3);
        push_pkt(1, 0, 3);
        push_pkt(4, 6, 3);
        push_pkt(5, 2, 3);
        step(1'b0, 7'h7f, 7'h00);
        step(1'b0, 7'h7f, 7'h00);
        n_cmp++;
        if (rd_en !== 7'b0110011 || out_busy !== 7'b1000111) begin
            n_bad++;
            $display("FAIL parallel_grant got rd=%b busy=%b exp rd=0110011 busy=1000111", rd_en, out_busy);
        end
        for (int c = 0; c < 5; c++) step(1'b0, 7'h7f, 7'h00);
        n_cmp++;
        if (rd_cnt[0] !== 3 || rd_cnt[1] !== 3 || rd_cnt[4] !== 3 || rd_cnt[5] !== 3) begin
            n_bad++;
            $display("FAIL parallel_reads got %0d %0d %0d %0d exp 3 3 3 3", rd_cnt[0], rd_cnt[1], rd_cnt[4], rd_cnt[5]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_pkt(1, 0, 5);
        for (int c = 0; c < 10 && rd_cnt[1] < 3; c++) step(1'b0, 7'h7f, 7'h00);
        n_cmp++;
        if (rd_cnt[1] !== 3) begin
            n_bad++; $display("FAIL reset_mid_pre got %0d exp 3", rd_cnt[1]);
        end
        fq[1].delete();
        step(1'b1, 7'h7f, 7'h00);
        clear_logs();
        push_pkt(1, 0, 2);
        for (int c = 0; c < 5; c++) step(1'b0, 7'h7f, 7'h00);
        n_cmp++;
        if (rd_cnt[1] !== 2 || olog[0].size() != 2) begin
            n_bad++; $display("FAIL reset_mid_post got %0d exp 2", rd_cnt[1]);
        end
    endtask

    task automatic test_errors();
        do_reset();
        push_pkt(0, 0, 2);
        for (int c = 0; c < 5; c++) step(1'b0, 7'h7f, 7'h00);
        n_cmp++;
        if (err !== 1'b1 || rd_cnt[0] !== 0) begin
            n_bad++; $display("FAIL uturn got err=%b reads=%0d exp err=1 reads=0", err, rd_cnt[0]);
        end
        do_reset();
        push_pkt(4, 3, 1);
        for (int c = 0; c < 3; c++) step(1'b0, 7'h7f, 7'h00);
        n_cmp++;
        if (rd_cnt[4] !== 1 || out_busy[3] !== 1'b0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL single_flit got reads=%0d busy=%b err=%b exp 1 0 0", rd_cnt[4], out_busy[3], err);
        end
    endtask

    task automatic test_random();
        int d;
        logic [6:0] rdy, gap;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NP; i++) begin
                if (fq[i].size() == 0 && $urandom_range(3) == 0) begin
                    d = int'($urandom_range(NP - 2));
                    if (d >= i) d++;
                    push_pkt(i, d, int'($urandom_range(1, 5)));
                end
                rdy[i] = ($urandom_range(3) != 0);
                gap[i] = ($urandom_range(4) == 0);
            end
            step(1'b0, rdy, gap);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_vld = '0; req_dst = '0; flit_type = '0; out_ready = '0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_parallel();
        test_reset_mid();
        test_errors();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wormhole_sw_arbiter.md
Name: wormhole_sw_arbiter

Overview:
- Switch allocator and sequencer for the 7-port (E, W, N, S, PE, UP, DOWN) wormhole router.
- Takes per-input head-flit route requests from the routing units and runs one round-robin arbiter per output port.
- Holds each output locked to the winning input until that packet's tail flit crosses.
- Drives the input-FIFO read enables and the per-output crossbar mux selects.

Parameters:
- NPORT, 7, number of router ports; port index 0=E, 1=W, 2=N, 3=S, 4=PE, 5=UP, 6=DOWN.
- PW, 3, width of a port index / destination code.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_vld  in  NPORT  input FIFO i is non-empty.
- req_dst  in  NPORT*PW  output port requested by input i, from the RCU. Field i is [PW*i+:PW]. Code 7 means no route.
- flit_type  in  NPORT*2  type of the head-of-FIFO flit at input i, taken from flit bits [FW-1:FW-2]: 11 head, 10 body, 01 tail, 00 single-flit packet.
- out_ready  in  NPORT  downstream at output o can accept a flit this cycle.
- rd_en  out  NPORT  read enable for input FIFO i.
- out_vld  out  NPORT  output o carries a valid flit this cycle; drives the downstream request.
- out_sel  out  NPORT*PW  input index feeding output o's mux. Field o is [PW*o+:PW].
- out_busy  out  NPORT  output o is locked to a packet.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset: the clock is clk; rst is synchronous and active-high.
  - Edge with rst=1: all locks clear, all round-robin pointers set to 0, err cleared.
  - While rst=1, rd_en, out_vld, out_busy and out_sel are forced to 0 combinationally.
  - Reset mid-packet drops the lock; no flit is read in the reset cycle.
- Per-output state machine, two states:
  - IDLE: no owner.
  - LOCKED: owner register, PW bits.
- Candidate set for output o in IDLE: input i with all of the following:
  - req_vld[i] = 1;
  - flit_type[i] is 11 or 00;
  - req_dst[i] = o;
  - i ≠ o (U-turns are never granted);
  - input i is not owned by any output.
- Arbitration:
  - Round-robin search starts at ptr[o] and proceeds ptr, ptr+1, ... mod 7.
  - If a winner w exists, at the next edge: state becomes LOCKED, owner = w, ptr[o] = (w+1) mod 7.
  - The pointer is unchanged when there is no winner.
- Transfer in LOCKED: xfer[o] = req_vld[owner] & out_ready[o].
  - rd_en[owner] = xfer[o].
  - out_vld[o] = xfer[o].
  - out_sel[o] = owner.
  - out_busy[o] = 1.
  - All of these are combinational from the registered state.
- Release: an xfer whose flit_type is 01 or 00 returns the output to IDLE at the next edge.
- Latency:
  - Head visible at cycle N on an idle output: first read at cycle N+1.
  - Tail read at cycle M: the output is IDLE at M+1, and the next packet's first read is at M+2 at the earliest.
- Backpressure:
  - out_ready=0, or req_vld=0 while LOCKED: the lock is held and no read occurs.
  - No timeout.
- Exclusivity: each input has exactly one destination, so it is owned by at most one output. rd_en[i] is the OR over outputs of (owner==i & xfer); at most one term is ever active.
- Fairness: a waiting head is granted after at most 5 competing packets.
- err is set and held until reset on any of:
  - a head (11) transferred while LOCKED, which is passed through and keeps the lock;
  - a body or tail flit at an unowned input with req_vld=1 for 2 consecutive cycles;
  - req_vld with a head and req_dst = own index or 7.
- Simultaneous events:
  - Release and a new request for the same output in the same cycle: the new request waits one cycle, with no same-cycle re-grant.
  - Multiple outputs may grant in the same cycle.

Decomposition:
- Shared package noc_pkg holds:
  - NPORT, PW, FW=40;
  - port index constants P_E..P_DOWN;
  - flit-type codes FT_HEAD=2'b11, FT_BODY=2'b10, FT_TAIL=2'b01, FT_SINGLE=2'b00;
  - DST_NONE=3'd7;
  - state encodings S_IDLE and S_LOCKED.
- Sub-module rr_arb7: 7-bit request vector, 3-bit pointer in → valid plus 3-bit winner index out. Purely combinational, instantiated once per output.
- The pointer, owner and state registers live in wormhole_sw_arbiter.

Test Plan:
1. Single packet: input W (1) sends 11, 10, 10, 01 to E (0), out_ready=1 → out_busy[0] rises at cycle 1; rd_en[1]=1 and out_sel[0]=1 on cycles 1–4; output 0 IDLE at cycle 5; ptr[0]=2.
2. Contention: N, S, PE heads all to UP (5) at the same time, each a 2-flit packet, ptr=0 → grant order N(2), S(3), PE(4), each packet separated by a 1-cycle idle gap; no starvation.
3. Backpressure: locked W→E with out_ready[0]=0 for 3 cycles mid-packet → rd_en[1]=0 and out_vld[0]=0 for those cycles, lock held, remaining flits delivered in order afterward.
4. Parallel grants: E→W, W→E, PE→DOWN, UP→N all requested in one cycle → all four locked at the next edge; four concurrent rd_en with no cross-talk.
5. Reset mid-packet: rst=1 for 1 cycle after the 2nd body flit → all rd_en and out_busy forced to 0 that cycle; locks clear and ptr=0 after the edge; a new head is granted normally.
6. Errors: input E requests dst 0 (U-turn) → never granted, err=1. Separately, a single-flit (00) from PE to S → one read, and output S is idle the following cycle.
